// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: the op
// encoding seen on the request bus, the controller state type and a small
// decode helper.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } state_e;

    // Arithmetic ops (MULT/MULTU/DIV/DIVU) all have a zero top bit.
    function automatic logic isArith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bus between the issuing stage and the mul/div unit.
// The issuer is the master; the mul/div unit is the slave.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Arithmetic core of the mul/div unit: operand capture, magnitude
// preparation, one shift-add or restoring-subtract step per cycle, and the
// final sign fix-up presented combinationally to the controller.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture_i,
    input  logic             prep_i,
    input  logic             step_i,
    input  logic             isDiv_i,
    input  logic             isSigned_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             divZero_o,
    output logic [WIDTH-1:0] resHi_o,
    output logic [WIDTH-1:0] resLo_o
);

    logic [WIDTH-1:0]   aRaw_q;
    logic [WIDTH-1:0]   bRaw_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH:0]     rem_q;
    logic               resNeg_q;
    logic               remNeg_q;

    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] accMul_d;
    logic [WIDTH+1:0]   remShift;
    logic [WIDTH+1:0]   remDiff;
    logic               divFits;
    logic [WIDTH:0]     rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic [2*WIDTH-1:0] prodNeg;

    // Operand magnitudes and one iteration step for both multiply and divide.
    always_comb begin
        aNeg     = isSigned_i & aRaw_q[WIDTH-1];
        bNeg     = isSigned_i & bRaw_q[WIDTH-1];
        aMag     = aNeg ? -aRaw_q : aRaw_q;
        bMag     = bNeg ? -bRaw_q : bRaw_q;

        mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        accMul_d = {mulSum, acc_q[WIDTH-1:1]};

        remShift = {rem_q, acc_q[WIDTH-1]};
        remDiff  = remShift - {2'b00, opnd_q};
        divFits  = ~remDiff[WIDTH+1];
        rem_d    = divFits ? remDiff[WIDTH:0] : remShift[WIDTH:0];
        quo_d    = {acc_q[WIDTH-2:0], divFits};
    end

    // Sign fix-up and divide-by-zero substitution of the final result.
    always_comb begin
        divZero_o = isDiv_i && (bRaw_q == '0);
        prodNeg   = -acc_q;
        resHi_o   = acc_q[2*WIDTH-1:WIDTH];
        resLo_o   = acc_q[WIDTH-1:0];
        if (isDiv_i) begin
            if (divZero_o) begin
                resHi_o = aRaw_q;
                resLo_o = '1;
            end else begin
                resLo_o = resNeg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                resHi_o = remNeg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            end
        end else if (resNeg_q) begin
            resHi_o = prodNeg[2*WIDTH-1:WIDTH];
            resLo_o = prodNeg[WIDTH-1:0];
        end
    end

    // Operand capture, accumulator load in PREP and per-cycle iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aRaw_q   <= '0;
            bRaw_q   <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            resNeg_q <= 1'b0;
            remNeg_q <= 1'b0;
        end else begin
            if (capture_i) begin
                aRaw_q <= a_i;
                bRaw_q <= b_i;
            end
            if (prep_i) begin
                resNeg_q <= aNeg ^ bNeg;
                remNeg_q <= aNeg;
                rem_q    <= '0;
                if (isDiv_i) begin
                    opnd_q <= bMag;
                    acc_q  <= {{WIDTH{1'b0}}, aMag};
                end else begin
                    opnd_q <= aMag;
                    acc_q  <= {{WIDTH{1'b0}}, bMag};
                end
            end
            if (step_i) begin
                if (isDiv_i) begin
                    rem_q            <= rem_d;
                    acc_q[WIDTH-1:0] <= quo_d;
                end else begin
                    acc_q <= accMul_d;
                end
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Holds the controller FSM, iteration counter, handshake outputs and HI/LO;
// the arithmetic lives in muldiv_datapath.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e           state_q;
    logic [1:0]       opReg_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic             divZero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             dpCapture;
    logic             dpPrep;
    logic             dpStep;
    logic             dpIsDiv;
    logic             dpIsSigned;
    logic             dpDivZero;
    logic [WIDTH-1:0] dpResHi;
    logic [WIDTH-1:0] dpResLo;

    assign dpCapture  = (state_q == ST_IDLE) && bus.start && isArith(bus.op);
    assign dpPrep     = (state_q == ST_PREP);
    assign dpStep     = (state_q == ST_ITER);
    assign dpIsDiv    = opReg_q[1];
    assign dpIsSigned = ~opReg_q[0];

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture_i  (dpCapture),
        .prep_i     (dpPrep),
        .step_i     (dpStep),
        .isDiv_i    (dpIsDiv),
        .isSigned_i (dpIsSigned),
        .a_i        (bus.a),
        .b_i        (bus.b),
        .divZero_o  (dpDivZero),
        .resHi_o    (dpResHi),
        .resLo_o    (dpResLo)
    );

    // Controller FSM with registered busy/done/HI/LO/div_zero. A divide by
    // zero jumps straight to FIX but FIX keeps draining the counter, so the
    // latency matches a normal operation exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opReg_q   <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (isArith(bus.op)) begin
                            opReg_q   <= bus.op[1:0];
                            busy_q    <= 1'b1;
                            divZero_q <= 1'b0;
                            state_q   <= ST_PREP;
                        end else if (bus.op == OP_MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                ST_PREP: begin
                    count_q <= CNT_W'(WIDTH);
                    state_q <= (dpIsDiv && dpDivZero) ? ST_FIX : ST_ITER;
                end
                ST_ITER: begin
                    count_q <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (count_q != '0) begin
                        count_q <= count_q - CNT_W'(1);
                    end else begin
                        hi_q      <= dpResHi;
                        lo_q      <= dpResLo;
                        divZero_q <= dpDivZero;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = divZero_q;

endmodule
